// File: rtl/alarm_controller.sv
// Intrusion alarm sequencer: DISARMED -> EXIT -> ARMED -> ENTRY -> ALARM, timed by a tick prescaler.
// Define ALARM_MEMORY_EN to latch alarm_mem on ALARM entry until the next accepted arm.
//
// state    | meaning
// DISARMED | idle, alert ignored, waits for arm
// EXIT     | exit delay, beeping, alert ignored
// ARMED    | watching alert
// ENTRY    | entry delay, beeping, waiting for disarm
// ALARM    | siren on for SIREN_TIME ticks
module alarm_controller #(
    parameter int TICK_DIV    = 1000,
    parameter int EXIT_DELAY  = 30,
    parameter int ENTRY_DELAY = 15,
    parameter int SIREN_TIME  = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alert,
    input  logic       arm,
    input  logic       disarm,
    output logic       siren,
    output logic       armed,
    output logic       beep,
    output logic [2:0] state,
    output logic       alarm_mem
);

    localparam int MAX_EE    = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
    localparam int MAX_DELAY = (MAX_EE > SIREN_TIME) ? MAX_EE : SIREN_TIME;
    localparam int PW        = $clog2(TICK_DIV);
    localparam int TW        = $clog2(MAX_DELAY + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] EXIT_TC   = TW'(EXIT_DELAY - 1);
    localparam logic [TW-1:0] ENTRY_TC  = TW'(ENTRY_DELAY - 1);
    localparam logic [TW-1:0] SIREN_TC  = TW'(SIREN_TIME - 1);

    localparam logic [2:0] S_DISARMED = 3'd0;
    localparam logic [2:0] S_EXIT     = 3'd1;
    localparam logic [2:0] S_ARMED    = 3'd2;
    localparam logic [2:0] S_ENTRY    = 3'd3;
    localparam logic [2:0] S_ALARM    = 3'd4;

    logic [PW-1:0] presc;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          timed;
    logic          delay_state;
    logic          changing;
    logic [2:0]    state_nxt;

    assign tick        = (presc == PRESC_MAX);
    assign timed       = (state == S_EXIT) || (state == S_ENTRY) || (state == S_ALARM);
    assign delay_state = (state == S_EXIT) || (state == S_ENTRY);
    assign changing    = (state_nxt != state);

    always_comb begin
        state_nxt = state;
        case (state)
            S_DISARMED: if (arm && !disarm) state_nxt = S_EXIT;
            S_EXIT: begin
                if (disarm) state_nxt = S_DISARMED;
                else if (tick && tick_cnt == EXIT_TC) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (disarm) state_nxt = S_DISARMED;
                else if (alert) state_nxt = S_ENTRY;
            end
            S_ENTRY: begin
                if (disarm) state_nxt = S_DISARMED;
                else if (tick && tick_cnt == ENTRY_TC) state_nxt = S_ALARM;
            end
            S_ALARM: begin
                if (disarm) state_nxt = S_DISARMED;
                else if (tick && tick_cnt == SIREN_TC) state_nxt = S_ARMED;
            end
            default: state_nxt = S_DISARMED;
        endcase
    end

    // Counters idle at zero outside timed states so they start clean on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_DISARMED;
            presc    <= '0;
            tick_cnt <= '0;
            siren    <= 1'b0;
            armed    <= 1'b0;
            beep     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (changing || !timed) begin
                presc    <= '0;
                tick_cnt <= '0;
            end else if (tick) begin
                presc    <= '0;
                tick_cnt <= tick_cnt + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            siren <= (state_nxt == S_ALARM);
            armed <= (state_nxt == S_ARMED) || (state_nxt == S_ENTRY) || (state_nxt == S_ALARM);
            if (changing)
                beep <= (state_nxt == S_EXIT) || (state_nxt == S_ENTRY);
            else if (delay_state)
                beep <= tick ? ~beep : beep;
            else
                beep <= 1'b0;
        end
    end

`ifdef ALARM_MEMORY_EN
    always_ff @(posedge clk) begin
        if (rst)
            alarm_mem <= 1'b0;
        else if (state == S_DISARMED && state_nxt == S_EXIT)
            alarm_mem <= 1'b0;
        else if (state != S_ALARM && state_nxt == S_ALARM)
            alarm_mem <= 1'b1;
    end
`else
    assign alarm_mem = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with TICK_DIV=4, EXIT_DELAY=3, ENTRY_DELAY=2, SIREN_TIME=5.
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alert = 1'b0;
    logic       arm = 1'b0;
    logic       disarm = 1'b0;
    logic       siren, armed, beep, alarm_mem;
    logic [2:0] state;

`ifdef ALARM_MEMORY_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [6:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic mem_exp = 1'b0;

    alarm_controller #(
        .TICK_DIV(4), .EXIT_DELAY(3), .ENTRY_DELAY(2), .SIREN_TIME(5)
    ) dut (
        .clk(clk), .rst(rst), .alert(alert), .arm(arm), .disarm(disarm),
        .siren(siren), .armed(armed), .beep(beep), .state(state), .alarm_mem(alarm_mem)
    );

    always #5 clk = ~clk;

    task automatic chk();
        exp_t       e;
        logic [6:0] obs;
        e   = sb.pop_front();
        obs = {state, siren, armed, beep, alarm_mem};
        total++;
        assert (obs === e.v) else begin
            bad++;
            $error("FAIL %s obs{state,siren,armed,beep,mem}=%b expected=%b", e.tag, obs, e.v);
        end
    endtask

    // Drive inputs for one edge, queue the expected post-edge outputs, then compare.
    task automatic step(input logic a, input logic d, input logic al,
                        input logic [2:0] s, input logic sr, input logic ar,
                        input logic bp, input string tag);
        exp_t e;
        arm    = a;
        disarm = d;
        alert  = al;
        e.tag  = tag;
        e.v    = {s, sr, ar, bp, (MEM_EN ? mem_exp : 1'b0)};
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk();
    endtask

    // Arm pulse then full exit delay: beep 1,0,1 over ticks, ARMED after 12 cycles.
    task automatic do_exit(input string tag);
        for (int k = 0; k <= 12; k++) begin
            if (k == 0) mem_exp = 1'b0;
            step((k == 0), 1'b0, (k >= 2 && k <= 10),
                 (k < 12) ? 3'd1 : 3'd2, 1'b0, (k == 12),
                 (k < 12) && (((k / 4) % 2) == 0), tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "reset");
        step(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "reset_hold");
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "disarmed_alert");
        step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "arm_and_disarm");

        do_exit("exit1");
        step(1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, "armed_idle");
        step(1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, "arm_in_armed");

        // Full entry/alarm cycle, then alert at siren expiry re-enters ENTRY.
        for (int e = 1; e <= 31; e++) begin
            if (e == 9) mem_exp = 1'b1;
            if (e <= 8)
                step(1'b0, 1'b0, (e == 1 || (e >= 3 && e <= 5)), 3'd3, 1'b0, 1'b1,
                     (((e - 1) / 4) % 2) == 0, "entry");
            else if (e <= 28)
                step(1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, "alarm");
            else if (e == 29)
                step(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, "siren_expiry");
            else if (e == 30)
                step(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, "reentry");
            else
                step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "disarm_entry");
        end
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "mem_hold");

        do_exit("exit2");
        step(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "disarm_over_alert");

        do_exit("exit3");
        step(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, "entry_b1");
        step(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, "entry_b2");
        step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "disarm_third");
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "no_alarm");

        do_exit("exit4");
        for (int e = 1; e <= 11; e++) begin
            if (e == 9) mem_exp = 1'b1;
            if (e <= 8)
                step(1'b0, 1'b0, (e == 1), 3'd3, 1'b0, 1'b1, (((e - 1) / 4) % 2) == 0, "entry2");
            else
                step(1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, "alarm2");
        end
        rst     = 1'b1;
        mem_exp = 1'b0;
        step(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "rst_mid_alarm");
        rst = 1'b0;
        do_exit("exit_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
